// File: rtl/io_bus_ctrl.sv
// Memory-stage IO bus controller: decodes IO-window loads/stores onto a req/ack device bus and stalls until done.
// Optional macro IO_BUS_TIMEOUT_EN adds a REQ-state timeout that aborts to a bus error.
module io_bus_ctrl #(
    parameter int          NUM_DEV    = 2,
    parameter logic [23:0] IO_BASE_HI = 24'h00007F,
    parameter int          TIMEOUT    = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    m_ioread,
    input  logic                    m_iowrite,
    input  logic [31:0]             m_addr,
    input  logic [31:0]             m_wdata,
    input  logic [3:0]              m_be,
    output logic                    stall,
    output logic [31:0]             m_rdata,
    output logic                    bus_err,
    output logic [NUM_DEV-1:0]      dev_sel,
    output logic                    dev_we,
    output logic [3:0]              dev_addr,
    output logic [31:0]             dev_wdata,
    output logic [3:0]              dev_be,
    input  logic [32*NUM_DEV-1:0]   dev_rdata,
    input  logic [NUM_DEV-1:0]      dev_ack
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [NUM_DEV-1:0] dev_sel_q, dev_sel_d;
    logic               dev_we_q, dev_we_d;
    logic [3:0]         dev_addr_q, dev_addr_d;
    logic [31:0]        dev_wdata_q, dev_wdata_d;
    logic [3:0]         dev_be_q, dev_be_d;
    logic [31:0]        m_rdata_q, m_rdata_d;
    logic               bus_err_q, bus_err_d;
    logic [3:0]         sel_idx_q, sel_idx_d;

    logic               req;
    logic [3:0]         idx;
    logic               decode_ok;
    logic               acked;
    logic               timeout_hit;
    logic [NUM_DEV-1:0] idx_onehot;
    logic [31:0]        sel_rdata;
    logic [1:0]         unused_addr_lsb;

    assign req             = m_ioread | m_iowrite;
    assign idx             = m_addr[7:4];
    assign unused_addr_lsb = m_addr[1:0];
    assign decode_ok       = (m_addr[31:8] == IO_BASE_HI)
                           && ({1'b0, idx} < 5'(NUM_DEV))
                           && !(m_ioread && m_iowrite);
    // Only the selected device's ack counts; dev_sel is one-hot so this masks the rest.
    assign acked           = (state_q == S_REQ) && ((dev_ack & dev_sel_q) != '0);

`ifdef IO_BUS_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    assign timeout_hit = (state_q == S_REQ) && (cnt_q == 8'(TIMEOUT - 1));
`else
    // No timeout path in this build: REQ waits for ack indefinitely.
    assign timeout_hit = (TIMEOUT < 0);
`endif

    always_comb begin
        idx_onehot = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            idx_onehot[i] = (idx == 4'(i));
        end
    end

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (sel_idx_q == 4'(i)) begin
                sel_rdata = dev_rdata[32*i +: 32];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = decode_ok ? S_REQ : S_ERR;
                end
            end
            S_REQ: begin
                if (acked) begin
                    state_d = S_DONE;
                end else if (timeout_hit) begin
                    state_d = S_ERR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: stall plus next values of the registered bus outputs
    always_comb begin
        stall       = rst_n & (((state_q == S_IDLE) & req) | (state_q == S_REQ));
        dev_sel_d   = dev_sel_q;
        dev_we_d    = dev_we_q;
        dev_addr_d  = dev_addr_q;
        dev_wdata_d = dev_wdata_q;
        dev_be_d    = dev_be_q;
        m_rdata_d   = m_rdata_q;
        bus_err_d   = 1'b0;
        sel_idx_d   = sel_idx_q;
`ifdef IO_BUS_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req && decode_ok) begin
                    dev_sel_d   = idx_onehot;
                    dev_we_d    = m_iowrite;
                    dev_addr_d  = m_addr[3:0] & 4'b1100;
                    dev_wdata_d = m_wdata;
                    dev_be_d    = m_iowrite ? m_be : 4'b1111;
                    sel_idx_d   = idx;
`ifdef IO_BUS_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end else if (req) begin
                    bus_err_d = 1'b1;
                    m_rdata_d = '0;
                end
            end
            S_REQ: begin
                if (acked) begin
                    dev_sel_d = '0;
                    dev_we_d  = 1'b0;
                    if (!dev_we_q) begin
                        m_rdata_d = sel_rdata;
                    end
                end else if (timeout_hit) begin
                    dev_sel_d = '0;
                    bus_err_d = 1'b1;
                    m_rdata_d = '0;
                end else begin
`ifdef IO_BUS_TIMEOUT_EN
                    cnt_d = cnt_q + 8'd1;
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dev_sel_q   <= '0;
            dev_we_q    <= 1'b0;
            dev_addr_q  <= '0;
            dev_wdata_q <= '0;
            dev_be_q    <= '0;
            m_rdata_q   <= '0;
            bus_err_q   <= 1'b0;
            sel_idx_q   <= '0;
`ifdef IO_BUS_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            dev_sel_q   <= dev_sel_d;
            dev_we_q    <= dev_we_d;
            dev_addr_q  <= dev_addr_d;
            dev_wdata_q <= dev_wdata_d;
            dev_be_q    <= dev_be_d;
            m_rdata_q   <= m_rdata_d;
            bus_err_q   <= bus_err_d;
            sel_idx_q   <= sel_idx_d;
`ifdef IO_BUS_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign dev_sel   = dev_sel_q;
    assign dev_we    = dev_we_q;
    assign dev_addr  = dev_addr_q;
    assign dev_wdata = dev_wdata_q;
    assign dev_be    = dev_be_q;
    assign m_rdata   = m_rdata_q;
    assign bus_err   = bus_err_q;

endmodule
